// File: rtl/mult_iter_16b_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM states and default widths.
package mult_iter_16b_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mult_state_t;

    localparam int unsigned MULT_N     = 16;
    localparam int unsigned MULT_CNT_W = 5;

    // Partial-product operand: multiplicand gated by the current multiplier bit.
    function automatic logic [MULT_N-1:0] pp_select(input logic sel, input logic [MULT_N-1:0] mcand);
        return {MULT_N{sel}} & mcand;
    endfunction

endpackage

// File: rtl/mult_iter_16b_if.sv
// start/busy/done handshake plus operands and product between execute control and the multiplier.
interface mult_iter_16b_if #(
    parameter int unsigned N = 16
) ();

    logic           i_start;
    logic [N-1:0]   i_a;
    logic [N-1:0]   i_b;
    logic           o_busy;
    logic           o_done;
    logic [2*N-1:0] o_product;

    modport master (
        output i_start, i_a, i_b,
        input  o_busy, o_done, o_product
    );

    modport slave (
        input  i_start, i_a, i_b,
        output o_busy, o_done, o_product
    );

endinterface

// File: rtl/mult_iter_16b_cla.sv
// Combinational carry-lookahead adder: cascaded 4-bit CLA slices, carry ripples between slices.
module cla_16b #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_c_in,
    output logic [W-1:0] o_sum,
    output logic         o_c_out
);

    logic [W/4:0] w_c;

    assign w_c[0] = i_c_in;

    for (genvar s = 0; s < W / 4; s++) begin : g_slice
        logic [3:0] w_g;
        logic [3:0] w_p;
        logic [3:0] w_ci;

        assign w_g = i_a[4*s +: 4] & i_b[4*s +: 4];
        assign w_p = i_a[4*s +: 4] ^ i_b[4*s +: 4];

        assign w_ci[0] = w_c[s];
        assign w_ci[1] = w_g[0] | (w_p[0] & w_c[s]);
        assign w_ci[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[s]);
        assign w_ci[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                       | (w_p[2] & w_p[1] & w_p[0] & w_c[s]);

        assign w_c[s+1] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                        | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                        | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[s]);

        assign o_sum[4*s +: 4] = w_p ^ w_ci;
    end

    assign o_c_out = w_c[W/4];

endmodule

// File: rtl/mult_iter_16b.sv
// Multi-cycle unsigned shift-add multiplier: one CLA add per cycle, product N+1 cycles after start.
module mult_iter_16b
    import mult_iter_16b_pkg::*;
#(
    parameter int unsigned N     = MULT_N,
    parameter int unsigned CNT_W = MULT_CNT_W
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mult_iter_16b_if.slave bus
);

    if ((N % 4) != 0) begin : g_bad_n
        $error("mult_iter_16b: N must be a multiple of 4");
    end
    if ((2 ** CNT_W) <= N) begin : g_bad_cnt_w
        $error("mult_iter_16b: CNT_W too narrow, counter would wrap inside RUN");
    end

    mult_state_t     r_state;
    mult_state_t     w_state_nxt;
    logic [N-1:0]    r_mcand;
    logic [2*N-1:0]  r_acc;
    logic [CNT_W-1:0] r_count;
    logic [2*N-1:0]  r_product;

    logic            w_accept;
    logic            w_last;
    logic [N-1:0]    w_addend;
    logic [N-1:0]    w_sum;
    logic            w_c_out;
    logic [2*N-1:0]  w_acc_iter;

    assign w_accept   = ((r_state == IDLE) || (r_state == DONE)) && bus.i_start;
    assign w_last     = (r_count == CNT_W'(N - 1));
    assign w_addend   = {N{r_acc[0]}} & r_mcand;
    // Carry-out re-enters at the MSB so the shifted accumulator never loses it.
    assign w_acc_iter = {w_c_out, w_sum, r_acc[N-1:1]};

    cla_16b #(.W(N)) u_cla (
        .i_a     (r_acc[2*N-1:N]),
        .i_b     (w_addend),
        .i_c_in  (1'b0),
        .o_sum   (w_sum),
        .o_c_out (w_c_out)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.i_start) w_state_nxt = RUN;
            RUN:     if (w_last)      w_state_nxt = DONE;
            DONE:    w_state_nxt = bus.i_start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mcand <= bus.i_a;
                r_acc   <= {{N{1'b0}}, bus.i_b};
                r_count <= '0;
            end else if (r_state == RUN) begin
                r_acc   <= w_acc_iter;
                r_count <= r_count + CNT_W'(1);
                if (w_last) r_product <= w_acc_iter;
            end
        end
    end

    assign bus.o_busy    = (r_state == RUN);
    assign bus.o_done    = (r_state == DONE);
    assign bus.o_product = r_product;

endmodule
